// File: rtl/tank_status.sv
// Per-frame tank status collector: ammo, position, health/life-cycle and kill score
// for up to TANK_NUM tanks, with respawn countdown and post-respawn invulnerability.
module tank_status #(
    parameter int unsigned TANK_NUM       = 2,
    parameter int unsigned BULLET_NUM     = 8,
    parameter int unsigned INIT_HEALTH    = 5,
    parameter int unsigned HEALTH_W       = 4,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 30,
    parameter int unsigned X_W            = 10,
    parameter int unsigned Y_W            = 10
) (
    input  logic                                  frame_clk,
    input  logic                                  Reset_n,
    input  logic                                  game_start,
    input  logic [TANK_NUM*BULLET_NUM-1:0]        bullet_active,
    input  logic [TANK_NUM*X_W-1:0]               tank_x,
    input  logic [TANK_NUM*Y_W-1:0]               tank_y,
    input  logic [TANK_NUM*BULLET_NUM*TANK_NUM-1:0] hit,
    output logic [32*TANK_NUM-1:0]                bullet_num_reg,
    output logic [32*TANK_NUM-1:0]                tank_pos_reg,
    output logic [32*TANK_NUM-1:0]                health_reg,
    output logic [32*TANK_NUM-1:0]                score_reg,
    output logic [TANK_NUM-1:0]                   kill_pulse
);

    localparam int unsigned NB    = TANK_NUM * BULLET_NUM;
    localparam int unsigned CNT_W = $clog2(NB + 1);
    localparam int unsigned HA_W  = (CNT_W > HEALTH_W) ? CNT_W : HEALTH_W;
    localparam int unsigned CR_W  = $clog2(TANK_NUM + 1);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } tank_state_e;

    tank_state_e       state_q  [TANK_NUM];
    tank_state_e       state_d  [TANK_NUM];
    logic [HA_W-1:0]   health_q [TANK_NUM];
    logic [HA_W-1:0]   health_d [TANK_NUM];
    logic [15:0]       timer_q  [TANK_NUM];
    logic [15:0]       timer_d  [TANK_NUM];
    logic [31:0]       score_q  [TANK_NUM];
    logic [31:0]       score_d  [TANK_NUM];
    logic [CNT_W-1:0]  free_q   [TANK_NUM];
    logic [CNT_W-1:0]  free_d   [TANK_NUM];
    logic [X_W-1:0]    x_q      [TANK_NUM];
    logic [Y_W-1:0]    y_q      [TANK_NUM];
    logic [TANK_NUM-1:0] alive_q;
    logic [TANK_NUM-1:0] alive_d;
    logic [TANK_NUM-1:0] pulse_q;
    logic [TANK_NUM-1:0] pulse_d;

    logic [CNT_W-1:0]  eff      [TANK_NUM];
    logic [TANK_NUM-1:0] dies;
    logic [CR_W-1:0]   credits  [TANK_NUM];
    logic [32:0]       score_sum;

    // Hit accounting: effective hits exclude self-hits; a shooter earns one credit per victim it hit
    always_comb begin
        for (int unsigned k = 0; k < TANK_NUM; k++) begin
            eff[k]     = '0;
            credits[k] = '0;
        end
        dies = '0;
        for (int unsigned k = 0; k < TANK_NUM; k++) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if ((i / BULLET_NUM) != k)
                    eff[k] = eff[k] + CNT_W'(hit[i*TANK_NUM + k]);
            end
            dies[k] = (state_q[k] == ST_ALIVE) && (eff[k] != '0)
                      && (HA_W'(eff[k]) >= health_q[k]);
        end
        for (int unsigned s = 0; s < TANK_NUM; s++) begin
            for (int unsigned k = 0; k < TANK_NUM; k++) begin
                if (k != s && dies[k]) begin
                    for (int unsigned b = 0; b < BULLET_NUM; b++) begin
                        if (hit[(s*BULLET_NUM + b)*TANK_NUM + k]) begin
                            credits[s] = credits[s] + CR_W'(1);
                            break;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        score_sum = '0;
        for (int unsigned t = 0; t < TANK_NUM; t++) begin
            state_d[t]  = state_q[t];
            health_d[t] = health_q[t];
            timer_d[t]  = timer_q[t];
            pulse_d[t]  = 1'b0;
            unique case (state_q[t])
                ST_ALIVE: begin
                    if (dies[t]) begin
                        state_d[t]  = ST_DEAD;
                        health_d[t] = '0;
                        timer_d[t]  = 16'(RESPAWN_FRAMES);
                        pulse_d[t]  = 1'b1;
                    end else begin
                        health_d[t] = health_q[t] - HA_W'(eff[t]);
                    end
                end
                ST_DEAD: begin
                    if (timer_q[t] == 16'd1) begin
                        health_d[t] = HA_W'(INIT_HEALTH);
                        if (INVULN_FRAMES == 0) begin
                            state_d[t] = ST_ALIVE;
                            timer_d[t] = '0;
                        end else begin
                            state_d[t] = ST_INVULN;
                            timer_d[t] = 16'(INVULN_FRAMES);
                        end
                    end else begin
                        timer_d[t] = timer_q[t] - 16'd1;
                    end
                end
                ST_INVULN: begin
                    if (timer_q[t] == 16'd1) begin
                        state_d[t] = ST_ALIVE;
                        timer_d[t] = '0;
                    end else begin
                        timer_d[t] = timer_q[t] - 16'd1;
                    end
                end
                default: begin
                    state_d[t] = ST_ALIVE;
                    timer_d[t] = '0;
                end
            endcase
            alive_d[t] = (state_d[t] != ST_DEAD);

            score_sum  = {1'b0, score_q[t]} + 33'(credits[t]);
            score_d[t] = score_sum[32] ? '1 : score_sum[31:0];

            free_d[t] = CNT_W'(BULLET_NUM) - CNT_W'($countones(bullet_active[t*BULLET_NUM +: BULLET_NUM]));
        end
    end

    // game_start shares the reset path; Reset_n only adds priority, the loaded values are identical
    always_ff @(posedge frame_clk) begin
        for (int unsigned t = 0; t < TANK_NUM; t++) begin
            if (!Reset_n || game_start) begin
                state_q[t]  <= ST_ALIVE;
                health_q[t] <= HA_W'(INIT_HEALTH);
                timer_q[t]  <= '0;
                score_q[t]  <= '0;
                free_q[t]   <= CNT_W'(BULLET_NUM);
                x_q[t]      <= '0;
                y_q[t]      <= '0;
                alive_q[t]  <= 1'b0;
                pulse_q[t]  <= 1'b0;
            end else begin
                state_q[t]  <= state_d[t];
                health_q[t] <= health_d[t];
                timer_q[t]  <= timer_d[t];
                score_q[t]  <= score_d[t];
                free_q[t]   <= free_d[t];
                x_q[t]      <= tank_x[t*X_W +: X_W];
                y_q[t]      <= tank_y[t*Y_W +: Y_W];
                alive_q[t]  <= alive_d[t];
                pulse_q[t]  <= pulse_d[t];
            end
        end
    end

    always_comb begin
        logic [31:0] pos_w;
        logic [31:0] hlt_w;
        bullet_num_reg = '0;
        tank_pos_reg   = '0;
        health_reg     = '0;
        score_reg      = '0;
        for (int unsigned t = 0; t < TANK_NUM; t++) begin
            pos_w                   = '0;
            pos_w[0]                = alive_q[t];
            pos_w[X_W:1]            = x_q[t];
            pos_w[X_W+Y_W:X_W+1]    = y_q[t];
            hlt_w                   = '0;
            hlt_w[HEALTH_W-1:0]     = health_q[t][HEALTH_W-1:0];
            hlt_w[9:8]              = state_q[t];
            hlt_w[31:16]            = timer_q[t];
            bullet_num_reg[t*32 +: 32] = 32'(free_q[t]);
            tank_pos_reg[t*32 +: 32]   = pos_w;
            health_reg[t*32 +: 32]     = hlt_w;
            score_reg[t*32 +: 32]      = score_q[t];
        end
    end

    assign kill_pulse = pulse_q;

endmodule

// File: tb/tb_tank_status.sv
// Self-checking bench for tank_status: directed life-cycle scenarios with literal
// expectations, then randomized frames checked every cycle against a frame-count model.
module tb_tank_status;

    localparam int TN = 2;
    localparam int BN = 8;
    localparam int INIT = 5;
    localparam int R = 4;
    localparam int I = 2;
    localparam int XW = 10;
    localparam int YW = 10;

    logic                 frame_clk;
    logic                 Reset_n;
    logic                 game_start;
    logic [TN*BN-1:0]     bullet_active;
    logic [TN*XW-1:0]     tank_x;
    logic [TN*YW-1:0]     tank_y;
    logic [TN*BN*TN-1:0]  hit;
    logic [32*TN-1:0]     bullet_num_reg;
    logic [32*TN-1:0]     tank_pos_reg;
    logic [32*TN-1:0]     health_reg;
    logic [32*TN-1:0]     score_reg;
    logic [TN-1:0]        kill_pulse;

    tank_status #(
        .TANK_NUM(TN), .BULLET_NUM(BN), .INIT_HEALTH(INIT), .HEALTH_W(4),
        .RESPAWN_FRAMES(R), .INVULN_FRAMES(I), .X_W(XW), .Y_W(YW)
    ) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .game_start(game_start),
        .bullet_active(bullet_active), .tank_x(tank_x), .tank_y(tank_y), .hit(hit),
        .bullet_num_reg(bullet_num_reg), .tank_pos_reg(tank_pos_reg),
        .health_reg(health_reg), .score_reg(score_reg), .kill_pulse(kill_pulse)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: life cycle tracked as frames elapsed since the kill (-1 = normal play)
    int          m_since  [TN];
    int          m_health [TN];
    longint      m_score  [TN];
    int          m_shots  [TN][TN];
    bit          m_died   [TN];
    logic [31:0] e_free   [TN];
    logic [31:0] e_pos    [TN];
    logic [31:0] e_health [TN];
    logic [31:0] e_score  [TN];
    logic [TN-1:0] e_pulse;

    task automatic model_step();
        int eff;
        int st;
        int tmr;
        bit alive;
        if (!Reset_n || game_start) begin
            for (int t = 0; t < TN; t++) begin
                m_since[t] = -1; m_health[t] = INIT; m_score[t] = 0; m_died[t] = 0;
                e_free[t] = BN; e_pos[t] = 0;
            end
        end else begin
            for (int s = 0; s < TN; s++)
                for (int k = 0; k < TN; k++) begin
                    m_shots[s][k] = 0;
                    for (int b = 0; b < BN; b++)
                        m_shots[s][k] += int'(hit[(s*BN+b)*TN+k]);
                end
            for (int k = 0; k < TN; k++) begin
                m_died[k] = 0;
                if (m_since[k] < 0) begin
                    eff = 0;
                    for (int s = 0; s < TN; s++) if (s != k) eff += m_shots[s][k];
                    if (eff > 0) begin
                        if (eff < m_health[k]) m_health[k] -= eff;
                        else begin m_health[k] = 0; m_since[k] = 0; m_died[k] = 1; end
                    end
                end else begin
                    m_since[k]++;
                    if (m_since[k] == R) m_health[k] = INIT;
                    if (m_since[k] >= R + I) m_since[k] = -1;
                end
            end
            for (int s = 0; s < TN; s++)
                for (int k = 0; k < TN; k++)
                    if (k != s && m_died[k] && m_shots[s][k] > 0)
                        m_score[s] = (m_score[s] + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_score[s] + 1;
            for (int t = 0; t < TN; t++) begin
                alive = (m_since[t] < 0) || (m_since[t] >= R);
                e_free[t] = BN - $countones(bullet_active[t*BN +: BN]);
                e_pos[t] = 32'(alive) + 32'(tank_x[t*XW +: XW]) * 2 + 32'(tank_y[t*YW +: YW]) * 2048;
            end
        end
        for (int t = 0; t < TN; t++) begin
            if (m_since[t] < 0)      begin st = 0; tmr = 0; end
            else if (m_since[t] < R) begin st = 2; tmr = R - m_since[t]; end
            else                     begin st = 1; tmr = R + I - m_since[t]; end
            e_health[t] = m_health[t] + st * 256 + tmr * 65536;
            e_score[t]  = m_score[t][31:0];
            e_pulse[t]  = m_died[t];
        end
    endtask

    always @(posedge frame_clk) model_step();

    task automatic compare_all();
        for (int t = 0; t < TN; t++) begin
            check($sformatf("bullet_num[%0d]", t), bullet_num_reg[t*32 +: 32], e_free[t]);
            check($sformatf("tank_pos[%0d]", t),   tank_pos_reg[t*32 +: 32],   e_pos[t]);
            check($sformatf("health[%0d]", t),     health_reg[t*32 +: 32],     e_health[t]);
            check($sformatf("score[%0d]", t),      score_reg[t*32 +: 32],      e_score[t]);
        end
        check("kill_pulse", 32'(kill_pulse), 32'(e_pulse));
    endtask

    always @(negedge frame_clk) if (chk_en) compare_all();

    task automatic frame();
        @(negedge frame_clk);
    endtask

    function automatic logic [31:0] w(input logic [32*TN-1:0] v, input int t);
        return v[t*32 +: 32];
    endfunction

    logic [31:0] dead_seq [6];

    initial begin
        dead_seq = '{32'h0003_0200, 32'h0002_0200, 32'h0001_0200,
                     32'h0002_0105, 32'h0001_0105, 32'h0000_0005};
        Reset_n = 1'b0; game_start = 1'b0;
        bullet_active = '0; tank_x = '0; tank_y = '0; hit = '0;
        frame();
        chk_en = 1'b1;
        frame();
        check("rst free0",  w(bullet_num_reg, 0), 32'd8);
        check("rst free1",  w(bullet_num_reg, 1), 32'd8);
        check("rst pos1",   w(tank_pos_reg, 1),   32'd0);
        check("rst health0", w(health_reg, 0),    32'd5);
        check("rst score1", w(score_reg, 1),      32'd0);
        check("rst pulse",  32'(kill_pulse),      32'd0);

        Reset_n = 1'b1;
        bullet_active = 16'h0029;
        frame();
        check("ammo free0", w(bullet_num_reg, 0), 32'd5);
        check("ammo free1", w(bullet_num_reg, 1), 32'd8);

        tank_x[19:10] = 10'd639; tank_y[19:10] = 10'd479;
        frame();
        check("pos1 corner", w(tank_pos_reg, 1), 32'd982271);

        hit = '0; hit[16] = 1'b1; hit[18] = 1'b1;
        frame();
        check("damage two", w(health_reg, 0), 32'd3);

        hit = '0; hit[4] = 1'b1;
        frame();
        check("self hit", w(health_reg, 0), 32'd3);

        hit = '0; hit[20] = 1'b1; hit[22] = 1'b1; hit[24] = 1'b1;
        frame();
        check("kill health0", w(health_reg, 0), 32'h0004_0200);
        check("kill pulse",   32'(kill_pulse),  32'd1);
        check("kill score1",  w(score_reg, 1),  32'd1);

        for (int j = 0; j < 6; j++) begin
            hit = '0; hit[16] = 1'b1;
            frame();
            check($sformatf("respawn seq %0d", j), w(health_reg, 0), dead_seq[j]);
            if (j == 0) check("pulse one cycle", 32'(kill_pulse), 32'd0);
        end

        hit = '0;
        hit[1] = 1'b1; hit[3] = 1'b1; hit[5] = 1'b1; hit[7] = 1'b1;
        hit[16] = 1'b1; hit[18] = 1'b1; hit[20] = 1'b1; hit[22] = 1'b1;
        frame();
        check("pre mutual h0", w(health_reg, 0), 32'd1);
        check("pre mutual h1", w(health_reg, 1), 32'd1);

        hit = '0; hit[1] = 1'b1; hit[16] = 1'b1;
        frame();
        check("mutual h0",     w(health_reg, 0), 32'h0004_0200);
        check("mutual h1",     w(health_reg, 1), 32'h0004_0200);
        check("mutual pulse",  32'(kill_pulse),  32'd3);
        check("mutual score0", w(score_reg, 0),  32'd1);
        check("mutual score1", w(score_reg, 1),  32'd2);
        check("dead pos1",     w(tank_pos_reg, 1), 32'd982270);

        hit = '0;
        frame(); frame();
        game_start = 1'b1;
        frame();
        check("gs health0", w(health_reg, 0), 32'd5);
        check("gs health1", w(health_reg, 1), 32'd5);
        check("gs score0",  w(score_reg, 0),  32'd0);
        check("gs score1",  w(score_reg, 1),  32'd0);
        check("gs pos1",    w(tank_pos_reg, 1), 32'd0);

        game_start = 1'b0;
        frame();
        Reset_n = 1'b0; game_start = 1'b1; bullet_active = 16'hFFFF;
        frame();
        check("rst+gs free0",  w(bullet_num_reg, 0), 32'd8);
        check("rst+gs pos1",   w(tank_pos_reg, 1),   32'd0);
        check("rst+gs health1", w(health_reg, 1),    32'd5);

        game_start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            Reset_n       = ($urandom_range(0, 499) != 0);
            game_start    = ($urandom_range(0, 299) == 0);
            bullet_active = 16'($urandom);
            tank_x        = 20'($urandom);
            tank_y        = 20'($urandom);
            hit           = $urandom & $urandom & $urandom & $urandom;
            frame();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tank_status.md
# tank_status

Per-frame status collector for up to `TANK_NUM` tanks. It samples bullet occupancy, tank coordinates and the bullet-to-tank hit matrix once per `frame_clk` cycle. It publishes read-only status words: ammo available, packed position, health with life-cycle state, and kill score. It also runs a per-tank life-cycle FSM (alive, dead with respawn countdown, post-respawn invulnerability). The block sits between the game-logic hardware (bullet and tank movers, collision detector) and the software-visible register file, and replaces the fixed two-tank, no-respawn status logic.

## Interface
Parameters:
- `TANK_NUM`, 2: number of tanks; 1–8.
- `BULLET_NUM`, 8: bullet slots per tank; 1–16.
- `INIT_HEALTH`, 5: health loaded at reset and at respawn; must be ≤ 2^`HEALTH_W`−1.
- `HEALTH_W`, 4: health field width.
- `RESPAWN_FRAMES`, 60: frames spent in DEAD; 1–65535.
- `INVULN_FRAMES`, 30: frames spent in INVULN after respawn; 0–65535 (0 = skip INVULN).
- `X_W`, 10 / `Y_W`, 10: coordinate widths; `X_W`+`Y_W` ≤ 31.

Ports:
- `frame_clk`, in, 1: frame clock; the only clock. All logic is on the rising edge.
- `Reset_n`, in, 1: synchronous, active-low reset.
- `game_start`, in, 1: synchronous soft re-init. It has the same effect as reset and lower priority than `Reset_n`.
- `bullet_active`, in, `TANK_NUM*BULLET_NUM`: bit t·`BULLET_NUM`+b = bullet b of tank t in flight.
- `tank_x`, in, `TANK_NUM*X_W`: packed x coordinate, tank t at slice t.
- `tank_y`, in, `TANK_NUM*Y_W`: packed y coordinate.
- `hit`, in, `TANK_NUM*BULLET_NUM*TANK_NUM`: bit i·`TANK_NUM`+k = global bullet i hit tank k this frame.
- `bullet_num_reg`, out, 32×`TANK_NUM`: free bullet slots per tank.
- `tank_pos_reg`, out, 32×`TANK_NUM`: packed position and alive flag.
- `health_reg`, out, 32×`TANK_NUM`: health, state and timer.
- `score_reg`, out, 32×`TANK_NUM`: kills credited to each tank.
- `kill_pulse`, out, `TANK_NUM`: one-cycle pulse when tank k enters DEAD.

## Operation
- `bullet_num_reg[t]` = `BULLET_NUM` − popcount(tank t's active bits), zero-extended to 32 bits.
- `tank_pos_reg[t]` packing:
  - bit0 = alive: 1 in ALIVE/INVULN, 0 in DEAD.
  - [`X_W`:1] = x.
  - [`X_W`+`Y_W`:`X_W`+1] = y.
  - Upper bits are 0.
  - Coordinates are sampled every frame regardless of state.
- `health_reg[t]` packing:
  - [`HEALTH_W`−1:0] = health.
  - [9:8] = state: 0 ALIVE, 1 INVULN, 2 DEAD.
  - [31:16] = remaining frames in the current timed state (0 in ALIVE).
  - All other bits are 0.
- Effective hits on tank k: `eff_k` = popcount over i of hit[i][k], where the owner of bullet i (i / `BULLET_NUM`) ≠ k. Self-hits are ignored.
- FSM per tank:
  - ALIVE:
    - If `eff_k` = 0: no change.
    - If `eff_k` < health: health −= `eff_k`.
    - If `eff_k` ≥ health: health saturates to 0, state → DEAD, timer = `RESPAWN_FRAMES`, `kill_pulse[k]` = 1.
  - DEAD: hits are ignored; timer decrements by 1 each frame.
    - When timer = 1, next state is INVULN with timer = `INVULN_FRAMES` and health = `INIT_HEALTH`.
    - If `INVULN_FRAMES` = 0, it goes directly to ALIVE instead.
  - INVULN: hits are ignored; timer decrements each frame. When timer = 1, next state is ALIVE with timer 0.
- Kill credit: on tank k's ALIVE→DEAD frame, every shooter tank s ≠ k with at least one hit on k that frame gets `score_reg[s]` += 1.
  - Score saturates at 0xFFFFFFFF.
  - A tank receiving several kill credits in one frame (several victims) adds the number of victims.
- Health arithmetic uses at least $clog2(`TANK_NUM*BULLET_NUM`+1) bits. Health never wraps below 0.

## Timing
- All outputs are registered. Inputs sampled at edge n appear on the outputs after edge n; latency is 1 frame.
- Reset or `game_start` values:
  - `bullet_num_reg` = `BULLET_NUM`.
  - `tank_pos_reg` = 0.
  - `health_reg` = `INIT_HEALTH` with state ALIVE and timer 0.
  - `score_reg` = 0.
  - `kill_pulse` = 0.
- Reset mid-countdown aborts DEAD/INVULN immediately. There is no pending credit or pulse afterwards.
- `kill_pulse` is high for exactly one cycle, coincident with the first cycle `health_reg` shows DEAD.
- Mutual kill in one frame: both tanks enter DEAD, both pulse, and each scores 1.
- A tank leaves DEAD exactly `RESPAWN_FRAMES` cycles after its kill edge. It is hittable again `INVULN_FRAMES` cycles after that.
- Register writes from the bus are not supported. Outputs are read-only status.

## Test plan
- Reset with `TANK_NUM`=2, `BULLET_NUM`=8 and no activity: every word holds its reset value. Then bullets 0,3,5 of tank 0 go active → `bullet_num_reg[0]`=5 one frame later; `bullet_num_reg[1]` stays 8.
- Position: tank 1 at x=639, y=479 → `tank_pos_reg[1]` = 1 | 639<<1 | 479<<11. After tank 1 is killed, bit0=0 while x/y keep tracking.
- Damage and self-hit:
  - Tank-1 bullets 8 and 9 hit tank 0 → health 3.
  - Tank-0 bullet 2 hits tank 0 → health stays 3.
  - Three tank-1 hits at health 3 → health 0, DEAD, `kill_pulse[0]` for one cycle, `score_reg[1]`=1.
- Respawn (`RESPAWN_FRAMES`=4, `INVULN_FRAMES`=2):
  - Hits during DEAD/INVULN have no effect.
  - State sequence: DEAD timers 4,3,2,1 → INVULN 2,1 with health 5 → ALIVE timer 0.
- Mutual kill: both tanks at health 1 hit each other in the same frame → both DEAD, both pulse, both scores increment.
- `game_start` asserted mid-countdown with nonzero scores → all tanks ALIVE, health 5, scores 0 one frame later. Then `Reset_n`=0 and `game_start`=1 together → reset values.
